m31_circulant_matvec_seq: RTL

Sequential M31 (p = 2^31-1) circulant matrix-vector multiplier for the Monolith permutation's linear layer.
- Accepts a whole state vector through a valid/ready handshake.
- Computes out[i] = sum_j COEFF[(j-i) mod VECTOR_SIZE] * x[j] mod p, one multiply-accumulate per clock.
- Streams the result vector back one element at a time through a second valid/ready handshake.
- Trades the area of a parallel reduction tree for VECTOR_SIZE^2 cycles of latency.

---
 rtl/m31_circulant_matvec_seq_if.sv | 49 ++++
 rtl/m31_circulant_matvec_seq.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/m31_circulant_matvec_seq_if.sv
// ---------------------------------------------------------------------------
// m31_circulant_matvec_seq_if
//
// Handshake bundle for m31_circulant_matvec_seq.
//   in_valid / in_ready / in_vec   : whole-vector input (packed, element 0 first)
//   out_valid / out_ready          : per-element output handshake
//   out_data / out_index / out_last: result element, its row, last-row flag
// The slave modport is the multiplier; the master modport is its environment.
// ---------------------------------------------------------------------------

interface m31_circulant_matvec_seq_if #(
    parameter int WORD_WIDTH  = 31,
    parameter int VECTOR_SIZE = 16
);

    localparam int IW = $clog2(VECTOR_SIZE);

    logic                                   in_valid;
    logic                                   in_ready;
    logic [0:VECTOR_SIZE-1][WORD_WIDTH-1:0] in_vec;
    logic                                   out_valid;
    logic                                   out_ready;
    logic [WORD_WIDTH-1:0]                  out_data;
    logic [IW-1:0]                          out_index;
    logic                                   out_last;

    modport slave (
        input  in_valid,
        input  in_vec,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_index,
        output out_last
    );

    modport master (
        output in_valid,
        output in_vec,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_index,
        input  out_last
    );

endinterface

// File: rtl/m31_circulant_matvec_seq.sv
// ---------------------------------------------------------------------------
// m31_circulant_matvec_seq
//
// Sequential circulant matrix-vector multiplier over the Mersenne field
// p = 2^WORD_WIDTH - 1 (M31 for the default width). It serves as the linear
// layer of the Monolith permutation:
//
//     out[i] = sum_j COEFF[(j - i) mod VECTOR_SIZE] * x[j]   (mod p)
//
// A whole vector is accepted in one handshake. The block then performs one
// multiply-accumulate per clock and streams each row result out through a
// second handshake. Row i is computed only after row i-1 has been consumed.
//
// Ports
//   clk              clock, rising-edge active
//   reset            asynchronous, active-high reset
//   bus (slave)      in_valid / in_ready / in_vec       vector input handshake
//                    out_valid / out_ready / out_data /
//                    out_index / out_last               element output stream
// ---------------------------------------------------------------------------

package m31_circulant_matvec_seq_pkg;

    // Coefficient tables are stored in a fixed-size container. This lets the
    // default row be a function call regardless of VECTOR_SIZE. Only the first
    // VECTOR_SIZE entries are used, and only their low WORD_WIDTH bits.
    localparam int MAX_VECTOR_SIZE = 256;

    typedef logic [MAX_VECTOR_SIZE-1:0][31:0] coeff_tab_t;

    // Default first circulant row: COEFF[k] = k + 1
    function automatic coeff_tab_t default_coeff();
        coeff_tab_t t;
        for (int k = 0; k < MAX_VECTOR_SIZE; k++) begin
            t[k] = 32'(k + 1);
        end
        return t;
    endfunction

endpackage

module m31_circulant_matvec_seq
    import m31_circulant_matvec_seq_pkg::*;
#(
    parameter int         WORD_WIDTH  = 31,
    parameter int         VECTOR_SIZE = 16,
    parameter coeff_tab_t COEFF       = default_coeff()
) (
    input  logic                             clk,
    input  logic                             reset,
    m31_circulant_matvec_seq_if.slave        bus
);

    localparam int                  IW       = $clog2(VECTOR_SIZE);
    localparam logic [WORD_WIDTH-1:0] P      = {WORD_WIDTH{1'b1}};
    localparam logic [IW-1:0]       LAST_IDX = IW'(VECTOR_SIZE - 1);
    localparam logic [IW:0]         N_EXT    = (IW + 1)'(VECTOR_SIZE);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPUTE = 2'd1,
        S_EMIT    = 2'd2
    } state_t;

    // Modular addition for two operands whose sum is below 2p. The carry out
    // of the W-bit add, or an all-ones sum, means the sum is >= p. In that
    // case subtracting p modulo 2^W gives the exact reduced value.
    function automatic logic [WORD_WIDTH-1:0] add_mod(
        input logic [WORD_WIDTH-1:0] a,
        input logic [WORD_WIDTH-1:0] b
    );
        logic                  c;
        logic [WORD_WIDTH-1:0] s;
        {c, s} = {1'b0, a} + {1'b0, b};
        if (c || (s == P)) begin
            add_mod = s - P;
        end else begin
            add_mod = s;
        end
    endfunction

    // Mersenne fold: 2^W == 1 (mod p), so hi*2^W + lo == hi + lo.
    // For canonical factors, hi < p and lo <= p. The fold sum is therefore
    // below 2p, and a single conditional subtract suffices.
    function automatic logic [WORD_WIDTH-1:0] red(
        input logic [2*WORD_WIDTH-1:0] prod
    );
        red = add_mod(prod[2*WORD_WIDTH-1:WORD_WIDTH], prod[WORD_WIDTH-1:0]);
    endfunction

    state_t                                   r_state;
    logic [0:VECTOR_SIZE-1][WORD_WIDTH-1:0]   r_x;
    logic [IW-1:0]                            r_row;
    logic [IW-1:0]                            r_col;
    logic [WORD_WIDTH-1:0]                    r_acc;
    logic [WORD_WIDTH-1:0]                    r_out_data;
    logic [IW-1:0]                            r_out_index;
    logic                                     r_out_valid;
    logic                                     r_out_last;
    logic                                     r_in_ready;

    logic [IW:0]                              w_diff;
    logic [7:0]                               w_coef_idx;
    logic [WORD_WIDTH-1:0]                    w_coef;
    logic [WORD_WIDTH-1:0]                    w_xcol;
    logic [2*WORD_WIDTH-1:0]                  w_prod;
    logic [WORD_WIDTH-1:0]                    w_acc_next;

    // Circulant index (col - row) mod N without a divider, then one MAC step
    always_comb begin
        w_diff = {1'b0, r_col} - {1'b0, r_row};
        if (r_col < r_row) begin
            w_diff = w_diff + N_EXT;
        end else begin
            w_diff = w_diff;
        end
        w_coef_idx = 8'(w_diff);
        w_coef     = COEFF[w_coef_idx][WORD_WIDTH-1:0];
        w_xcol     = r_x[r_col];
        w_prod     = {{WORD_WIDTH{1'b0}}, w_coef} * {{WORD_WIDTH{1'b0}}, w_xcol};
        w_acc_next = add_mod(r_acc, red(w_prod));
    end

    // Control FSM, datapath registers and registered handshake outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_x         <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_acc       <= '0;
            r_out_data  <= '0;
            r_out_index <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        // Canonicalise on capture: the value p is stored as 0
                        for (int i = 0; i < VECTOR_SIZE; i++) begin
                            r_x[i] <= (bus.in_vec[i] == P) ? '0 : bus.in_vec[i];
                        end
                        r_acc      <= '0;
                        r_row      <= '0;
                        r_col      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_COMPUTE;
                    end
                end

                S_COMPUTE: begin
                    if (r_col == LAST_IDX) begin
                        r_out_data  <= w_acc_next;
                        r_out_index <= r_row;
                        r_out_last  <= (r_row == LAST_IDX);
                        r_out_valid <= 1'b1;
                        r_acc       <= '0;
                        r_col       <= '0;
                        r_state     <= S_EMIT;
                    end else begin
                        r_acc <= w_acc_next;
                        r_col <= r_col + 1'b1;
                    end
                end

                S_EMIT: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        if (r_row == LAST_IDX) begin
                            r_in_ready <= 1'b1;
                            r_state    <= S_IDLE;
                        end else begin
                            r_row   <= r_row + 1'b1;
                            r_state <= S_COMPUTE;
                        end
                    end
                end

                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                    r_out_last  <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_index = r_out_index;
    assign bus.out_last  = r_out_last;

endmodule
